// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared opcodes, NOP encoding and branch funct3 codes for the RISC-V pipeline
package rv_pipe_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [2:0] F3_EQ = 3'b000;
  localparam logic [2:0] F3_NE = 3'b001;
  localparam logic [2:0] F3_LT = 3'b100;
  localparam logic [2:0] F3_GE = 3'b101;
  localparam logic [2:0] F3_LTU = 3'b110;
  localparam logic [2:0] F3_GEU = 3'b111;
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational branch condition evaluator
// ports: funct3 (branch kind), a/b (operands), taken (condition true; 010/011 never taken)
module branch_cmp
  import rv_pipe_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        taken
);
  always_comb
    taken = funct3 == F3_EQ  ? a == b :
            funct3 == F3_NE  ? a != b :
            funct3 == F3_LT  ? $signed(a) < $signed(b) :
            funct3 == F3_GE  ? $signed(a) >= $signed(b) :
            funct3 == F3_LTU ? a < b :
            funct3 == F3_GEU ? a >= b : 1'b0;
endmodule

// File: rtl/if_id_redirect.sv
// if_id_redirect: IF/ID register with ID-stage branch/jump resolution and hazard stalls
// inputs : clk, reset (async, active-high), Instruction_if/PC_if (fetch), IF_flush (wrong-path fetch),
//          rs1_data/rs2_data (forwarded operands), RegWrite_ex/MemRead_ex/Rd_ex, MemRead_mem/Rd_mem
// outputs: Instruction_id/PC_id/valid_id (ID slot), Branch/Jump/JumpAddr (redirect),
//          IFWrite (0 = fetch holds), Bubble_id (ID/EX loads NOP)
// config : define JALR_REDIRECT_EN to resolve JALR here; otherwise JALR is resolved downstream
module if_id_redirect
  import rv_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_if,
  input  logic [31:0] PC_if,
  input  logic        IF_flush,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic [4:0]  Rd_ex,
  input  logic        MemRead_mem,
  input  logic [4:0]  Rd_mem,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id,
  output logic        valid_id,
  output logic        Branch,
  output logic        Jump,
  output logic [31:0] JumpAddr,
  output logic        IFWrite,
  output logic        Bubble_id
);
`ifdef JALR_REDIRECT_EN
  localparam logic JALR_EN = 1'b1;
`else
  localparam logic JALR_EN = 1'b0;
`endif
  logic [6:0] op;
  logic [4:0] rs1, rs2;
  logic is_br, is_jal, is_jalr, ctrl, rs1_used, ex_hit, mem_hit, stall, br_taken;
  logic [31:0] b_imm, j_imm, i_imm;
  branch_cmp u_cmp (.funct3(Instruction_id[14:12]), .a(rs1_data), .b(rs2_data), .taken(br_taken));
  always_comb begin
    op = Instruction_id[6:0];
    rs1 = Instruction_id[19:15];
    rs2 = Instruction_id[24:20];
    b_imm = {{19{Instruction_id[31]}}, Instruction_id[31], Instruction_id[7], Instruction_id[30:25], Instruction_id[11:8], 1'b0};
    j_imm = {{11{Instruction_id[31]}}, Instruction_id[31], Instruction_id[19:12], Instruction_id[20], Instruction_id[30:21], 1'b0};
    i_imm = {{20{Instruction_id[31]}}, Instruction_id[31:20]};
    is_br = op == OP_BRANCH;
    is_jal = op == OP_JAL;
    is_jalr = JALR_EN && op == OP_JALR;
    ctrl = is_br || is_jalr;
    // rs1 is a real source for everything except JAL/LUI/AUIPC, and JALR when it is resolved downstream
    rs1_used = !(is_jal || op == OP_LUI || op == OP_AUIPC || (!JALR_EN && op == OP_JALR));
    ex_hit = Rd_ex != '0 && ((rs1_used && Rd_ex == rs1) || (is_br && Rd_ex == rs2));
    mem_hit = Rd_mem != '0 && ((ctrl && Rd_mem == rs1) || (is_br && Rd_mem == rs2));
    stall = valid_id && ((MemRead_ex && ex_hit) || (ctrl && RegWrite_ex && ex_hit) || (MemRead_mem && mem_hit));
    Branch = valid_id && !stall && is_br && br_taken;
    Jump = valid_id && !stall && (is_jal || is_jalr);
    JumpAddr = Branch ? PC_id + b_imm :
               !Jump  ? 32'd0 :
               is_jal ? PC_id + j_imm : (rs1_data + i_imm) & ~32'd1;
    IFWrite = !stall;
    Bubble_id = stall || !valid_id;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      Instruction_id <= NOP;
      PC_id <= '0;
      valid_id <= 1'b0;
    end else if (!stall) begin
      Instruction_id <= IF_flush ? NOP : Instruction_if;
      PC_id <= PC_if;
      valid_id <= !IF_flush;
    end
endmodule

// File: tb/tb_if_id_redirect.sv
// tb_if_id_redirect: directed plus randomized check of if_id_redirect against a behavioural model
module tb_if_id_redirect;
  logic clk, reset, IF_flush, RegWrite_ex, MemRead_ex, MemRead_mem;
  logic [31:0] Instruction_if, PC_if, rs1_data, rs2_data;
  logic [4:0] Rd_ex, Rd_mem;
  logic [31:0] Instruction_id, PC_id, JumpAddr;
  logic valid_id, Branch, Jump, IFWrite, Bubble_id;
  int total = 0, bad = 0;
`ifdef JALR_REDIRECT_EN
  localparam bit JEN = 1;
`else
  localparam bit JEN = 0;
`endif
  localparam logic [31:0] NOP_I = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] BEQ = 32'h0020_8863;
  localparam logic [31:0] ADD = 32'h0072_8333;
  localparam logic [31:0] BNE = 32'h0002_9463;
  localparam logic [31:0] JALR_I = 32'h0071_80E7;
  localparam logic [31:0] JAL_I = 32'h0200_006F;

  if_id_redirect dut (
    .clk(clk), .reset(reset), .Instruction_if(Instruction_if), .PC_if(PC_if), .IF_flush(IF_flush),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
    .Rd_ex(Rd_ex), .MemRead_mem(MemRead_mem), .Rd_mem(Rd_mem), .Instruction_id(Instruction_id),
    .PC_id(PC_id), .valid_id(valid_id), .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr),
    .IFWrite(IFWrite), .Bubble_id(Bubble_id)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  logic [31:0] m_instr, m_pc;
  logic m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return !($signed(a) < $signed(b));
      3'd6: return a < b;
      3'd7: return !(a < b);
      default: return 0;
    endcase
  endfunction

  // expected combinational outputs from the ID-slot model and the current inputs
  task automatic model(output bit st, output bit br, output bit jp, output logic [31:0] tgt);
    int op, s1, s2;
    bit is_b, is_j, is_r, need1;
    logic [31:0] boff, joff, ioff;
    op = int'(m_instr[6:0]);
    s1 = int'(m_instr[19:15]);
    s2 = int'(m_instr[24:20]);
    is_b = op == 'h63;
    is_j = op == 'h6F;
    is_r = JEN && op == 'h67;
    need1 = !(op == 'h6F || op == 'h37 || op == 'h17 || op == 'h67 && !JEN);
    st = 0;
    if (m_valid) begin
      if (MemRead_ex && Rd_ex != 0 && ((need1 && Rd_ex == s1) || (is_b && Rd_ex == s2))) st = 1;
      if ((is_b || is_r) && RegWrite_ex && Rd_ex != 0 && (Rd_ex == s1 || (is_b && Rd_ex == s2))) st = 1;
      if ((is_b || is_r) && MemRead_mem && Rd_mem != 0 && (Rd_mem == s1 || (is_b && Rd_mem == s2))) st = 1;
    end
    boff = $signed({m_instr[31], m_instr[7], m_instr[30:25], m_instr[11:8], 1'b0});
    joff = $signed({m_instr[31], m_instr[19:12], m_instr[20], m_instr[30:21], 1'b0});
    ioff = $signed(m_instr[31:20]);
    br = m_valid && !st && is_b && cond(m_instr[14:12], rs1_data, rs2_data);
    jp = m_valid && !st && (is_j || is_r);
    tgt = 0;
    if (br) tgt = m_pc + boff;
    else if (jp && is_j) tgt = m_pc + joff;
    else if (jp) tgt = (rs1_data + ioff) - ((rs1_data + ioff) % 2);
  endtask

  // compare all outputs against the model, then advance one clock
  task automatic cyc();
    bit st, br, jp;
    logic [31:0] tgt;
    #1;
    if (reset) begin m_instr = NOP_I; m_pc = 0; m_valid = 0; end
    model(st, br, jp, tgt);
    chk("Instruction_id", Instruction_id, m_instr);
    chk("PC_id", PC_id, m_pc);
    chk("valid_id", 32'(valid_id), 32'(m_valid));
    chk("Branch", 32'(Branch), 32'(br));
    chk("Jump", 32'(Jump), 32'(jp));
    chk("JumpAddr", JumpAddr, tgt);
    chk("IFWrite", 32'(IFWrite), 32'(!st));
    chk("Bubble_id", 32'(Bubble_id), 32'(st || !m_valid));
    @(posedge clk);
    if (reset) begin m_instr = NOP_I; m_pc = 0; m_valid = 0; end
    else if (!st) begin
      m_instr = IF_flush ? NOP_I : Instruction_if;
      m_pc = PC_if;
      m_valid = !IF_flush;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [6:0] ops [7] = '{7'h63, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h03};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 6)];
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  function automatic logic [31:0] rnd_data();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 3)) - 32'd1;
  endfunction

  task automatic quiet();
    IF_flush = 0; RegWrite_ex = 0; MemRead_ex = 0; Rd_ex = 0; MemRead_mem = 0; Rd_mem = 0;
  endtask

  initial begin
    reset = 1; quiet();
    Instruction_if = NOP_I; PC_if = 0; rs1_data = 0; rs2_data = 0;
    m_instr = NOP_I; m_pc = 0; m_valid = 0;
    @(negedge clk);
    cyc();
    chk("rst IFWrite", 32'(IFWrite), 1);
    chk("rst Bubble_id", 32'(Bubble_id), 1);
    chk("rst Instruction_id", Instruction_id, 32'h13);
    reset = 0; Instruction_if = ADDI; PC_if = 0;
    #1 chk("first held valid", 32'(valid_id), 0);
    cyc();
    chk("first PC_id", PC_id, 0);
    chk("first valid", 32'(valid_id), 1);
    Instruction_if = BEQ; PC_if = 32'h40;
    cyc();
    rs1_data = 5; rs2_data = 6; Instruction_if = 32'hDEAD_BEEF; PC_if = 32'h44;
    #1 chk("beq ne Branch", 32'(Branch), 0);
    rs2_data = 5; IF_flush = 1;
    #1 chk("beq Branch", 32'(Branch), 1);
    chk("beq target", JumpAddr, 32'h50);
    cyc();
    chk("flush valid", 32'(valid_id), 0);
    IF_flush = 0; Instruction_if = ADD; PC_if = 32'h80;
    cyc();
    MemRead_ex = 1; RegWrite_ex = 1; Rd_ex = 5; Instruction_if = NOP_I; PC_if = 32'h84;
    #1 chk("lu IFWrite", 32'(IFWrite), 0);
    chk("lu Bubble", 32'(Bubble_id), 1);
    cyc();
    chk("lu held", Instruction_id, ADD);
    quiet();
    #1 chk("lu released", 32'(IFWrite), 1);
    Instruction_if = BNE; PC_if = 32'h100;
    cyc();
    cyc();
    rs1_data = 1; rs2_data = 0; MemRead_ex = 1; RegWrite_ex = 1; Rd_ex = 5; Instruction_if = ADDI; PC_if = 32'h104;
    #1 chk("bl stall1", 32'(IFWrite), 0);
    cyc();
    quiet(); MemRead_mem = 1; Rd_mem = 5;
    #1 chk("bl stall2", 32'(IFWrite), 0);
    chk("bl no branch", 32'(Branch), 0);
    cyc();
    quiet(); Instruction_if = BNE; PC_if = 32'h100;
    #1 chk("bl Branch", 32'(Branch), 1);
    chk("bl target", JumpAddr, 32'h108);
    cyc();
    MemRead_ex = 1; Rd_ex = 0;
    #1 chk("rd0 no stall", 32'(IFWrite), 1);
    cyc();
    quiet(); Instruction_if = JALR_I; PC_if = 32'h200;
    cyc();
    rs1_data = 32'h100;
    #1 chk("jalr Jump", 32'(Jump), 32'(JEN));
    chk("jalr target", JumpAddr, JEN ? 32'h106 : 32'h0);
    Instruction_if = JAL_I; PC_if = 32'hFFFF_FFF0;
    cyc();
    #1 chk("jal Jump", 32'(Jump), 1);
    chk("jal wrap", JumpAddr, 32'h10);
    Instruction_if = ADD; PC_if = 32'h2C0;
    cyc();
    cyc();
    MemRead_ex = 1; Rd_ex = 5;
    #1 chk("mid stall", 32'(IFWrite), 0);
    #2 reset = 1;
    #1 chk("async rst valid", 32'(valid_id), 0);
    chk("async rst IFWrite", 32'(IFWrite), 1);
    cyc();
    reset = 0; quiet(); Instruction_if = ADDI; PC_if = 32'h300;
    cyc();
    chk("post rst PC", PC_id, 32'h300);
    chk("post rst valid", 32'(valid_id), 1);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 99) == 0;
      Instruction_if = rnd_instr();
      PC_if = $urandom & ~32'd3;
      IF_flush = $urandom_range(0, 4) == 0;
      rs1_data = rnd_data();
      rs2_data = rnd_data();
      RegWrite_ex = $urandom_range(0, 2) == 0;
      MemRead_ex = $urandom_range(0, 3) == 0;
      Rd_ex = 5'($urandom_range(0, 7));
      MemRead_mem = $urandom_range(0, 3) == 0;
      Rd_mem = 5'($urandom_range(0, 7));
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_id_redirect.md
# if_id_redirect

IF/ID pipeline register plus ID-stage control-flow resolver for the five-stage RISC-V core; the consuming end of the fetch interface. It captures the fetched instruction and PC, resolves branches, JAL and JALR in ID, and drives the redirect and stall controls back to the fetch stage: `Branch`, `Jump`, `JumpAddr` and `IFWrite`. It also detects load-use and branch-operand hazards and inserts bubbles toward ID/EX.

## Interface
- No parameters (widths fixed: XLEN 32, register index 5).
- `clk` in 1: sole clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `Instruction_if` in 32: instruction fetched at `PC_if`.
- `PC_if` in 32: fetch-stage PC.
- `IF_flush` in 1: from fetch stage; the instruction currently in IF is on the wrong path.
- `rs1_data`, `rs2_data` in 32 each: already-forwarded operand values for the ID instruction.
- `RegWrite_ex`, `MemRead_ex` in 1 each; `Rd_ex` in 5: EX-stage destination info.
- `MemRead_mem` in 1; `Rd_mem` in 5: MEM-stage load info.
- `Instruction_id` out 32: registered instruction.
- `PC_id` out 32: registered PC.
- `valid_id` out 1: ID slot holds a real instruction.
- `Branch` out 1: conditional branch taken (combinational).
- `Jump` out 1: JAL/JALR taken (combinational).
- `JumpAddr` out 32: redirect target.
- `IFWrite` out 1: 0 = fetch stage holds PC.
- `Bubble_id` out 1: ID/EX must load NOP this cycle.

## Operation
- **Decode of the ID instruction.**
  - Opcode 1100011 = branch.
  - Opcode 1101111 = JAL.
  - Opcode 1100111 = JALR.
  - rs1 = [19:15], rs2 = [24:20]. rs2 is used only by branches.
- **Branch conditions (funct3).** 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. funct3 010 and 011: never taken.
- **Targets.** All arithmetic is 32-bit, with wrap-around.
  - Branch: `PC_id` + sign-extended B-immediate.
  - JAL: `PC_id` + J-immediate.
  - JALR: (`rs1_data` + I-immediate) & ~1.
- **Hazard (`stall`).** Asserted when `valid_id` is 1 and any of the following holds:
  - load-use: `MemRead_ex` & `Rd_ex`≠0 & `Rd_ex` equals a used source register;
  - branch/JALR source written by EX: `RegWrite_ex` & `Rd_ex`≠0 & match;
  - branch/JALR source loaded in MEM: `MemRead_mem` & `Rd_mem`≠0 & match.
- **Control outputs.**
  - `IFWrite` = ~`stall`.
  - `Bubble_id` = `stall` | ~`valid_id`.
  - `Branch` = `valid_id` & ~`stall` & branch & condition.
  - `Jump` = `valid_id` & ~`stall` & (JAL | JALR).
  - When neither `Branch` nor `Jump` is asserted, `JumpAddr` = 0.
- **IF/ID register update.** Priority: `reset` > `stall` (hold) > `IF_flush` (load NOP 32'h00000013 with `valid_id`=0) > normal load of `Instruction_if`, `PC_if` with `valid_id`=1.
- `stall` and a redirect are mutually exclusive by construction. A redirect never coexists with `IFWrite`=0.

## Timing
- **Reset values.**
  - Registered state: `Instruction_id`=32'h00000013, `PC_id`=0, `valid_id`=0.
  - Control outputs consequently: `Branch`=0, `Jump`=0, `JumpAddr`=0, `IFWrite`=1, `Bubble_id`=1.
- **Latency.** IF→ID is 1 cycle. Redirect is combinational within the ID cycle; the wrong-path IF instruction is squashed at the same edge.
- **Taken control transfer costs 1 bubble.**
- **Stall durations.**
  - Load-use: exactly 1 cycle.
  - Branch on ALU result in EX: 1 cycle.
  - Branch on load in EX: 2 cycles (EX, then MEM).
- **Reset mid-stall.** All state clears asynchronously. The first edge after deassertion loads normally.

## Configuration
- `JALR_REDIRECT_EN` defined: JALR is resolved in ID as specified, and its rs1 participates in hazard checks.
- `JALR_REDIRECT_EN` undefined: opcode 1100111 is not a control transfer. `Jump` is asserted for JAL only, and JALR rs1 is not hazard-checked; JALR is resolved downstream.

## Structure
- Shared package `rv_pipe_pkg`: opcode constants (BRANCH, JAL, JALR, LOAD), NOP encoding 32'h00000013, branch funct3 codes.
- One sub-module `branch_cmp`: combinational, takes funct3, a, b; returns `taken`.

## Test plan
- **Reset and first fetch.** Assert reset, then feed `PC_if`=0x00, `Instruction_if`=addi. Required: one cycle later `PC_id`=0, `valid_id`=1; outputs held at reset values until then.
- **Taken branch.** `PC_id`=0x40 holding `beq x1,x2,+16` with `rs1_data`=`rs2_data`=5. Required: `Branch`=1, `JumpAddr`=0x50, `IF_flush` honoured, next `valid_id`=0. With `rs2_data`=6: `Branch`=0.
- **Load-use.** `lw x5` in EX (`MemRead_ex`=1, `Rd_ex`=5), ID holds `add x6,x5,x7`. Required: exactly 1 cycle of `IFWrite`=0 and `Bubble_id`=1, `Instruction_id` held.
- **Branch on load.** `bne x5,x0` in ID, load to x5 in EX. Required: 2 stall cycles, then branch resolves. Also `Rd_ex`=0 with `MemRead_ex`=1: no stall.
- **JALR.** `jalr x1,7(x3)` with `rs1_data`=0x100. Required: `Jump`=1, `JumpAddr`=0x106. With macro undefined: `Jump`=0.
- **Wrap-around.** `PC_id`=0xFFFFFFF0, `jal +0x20`. Required: `JumpAddr`=0x00000010.
